// File: rtl/tone_pkg.sv
// tone_pkg: constants and types shared by the audio-input tone blocks.
// HALF_* values are half-period counts of reference tones at 25 MHz.
package tone_pkg;

   localparam int unsigned HALF_400HZ = 31250;
   localparam int unsigned HALF_700HZ = 17857;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } tone_state_t;

   // True when a measured interval lies inside the inclusive window [lo, hi].
   function automatic logic inWindow(input logic [16:0] value,
                                     input logic [16:0] lo,
                                     input logic [16:0] hi);
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/tone_meter_edge_sync.sv
// edge_sync: brings an asynchronous level into the clock domain through two
// flops and emits a one-cycle pulse on every rising or falling transition.
module edge_sync (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_edge
);

   logic r_meta;
   logic r_sync;
   logic r_last;

   // Two synchronizer stages, then one delay stage to compare against.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_last <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_last <= r_sync;
      end
   end

   assign o_edge = r_sync ^ r_last;

endmodule

// File: rtl/tone_meter.sv
// tone_meter: measures the half-period of a square-wave audio input in clock
// cycles, strobes each in-window measurement and flags a stable tone.
// Optional pitch-sweep detection is enabled by defining SWEEP_DETECT_EN.
module tone_meter #(
   parameter int unsigned MIN_COUNT = 15000,
   parameter int unsigned MAX_COUNT = 40000,
   parameter int unsigned LOCK_N    = 4
) (
   input  logic        clock_25mhz,
   input  logic        reset,
   input  logic        audio_in,
   output logic [15:0] half_period,
   output logic        period_valid,
   output logic        tone_present,
   output logic        sweep_up,
   output logic        sweep_down
);

   import tone_pkg::*;

   localparam logic [16:0] MIN_V   = 17'(MIN_COUNT);
   localparam logic [16:0] MAX_V   = 17'(MAX_COUNT);
   localparam logic [15:0] MAX_CNT = 16'(MAX_COUNT);
   localparam logic [3:0]  LOCK_V  = 4'(LOCK_N);

   logic        w_edge;
   tone_state_t r_state;
   tone_state_t w_stateNext;
   logic [15:0] r_cnt;
   logic [15:0] w_cntNext;
   logic [3:0]  r_run;
   logic [3:0]  w_runNext;
   logic [15:0] r_halfPeriod;
   logic [15:0] w_halfNext;
   logic        r_valid;
   logic        w_validNext;
   logic        r_present;
   logic        w_presentNext;
   logic [16:0] w_measured;
   logic        w_inWindow;
   logic        w_accept;
   logic        w_reject;
   logic        w_timeout;

   edge_sync u_edgeSync (
      .i_clock (clock_25mhz),
      .i_reset (reset),
      .i_async (audio_in),
      .o_edge  (w_edge)
   );

   // Measured interval is one more than the cycles counted since the last edge;
   // an edge coinciding with the timeout yields MAX+1 and is therefore rejected.
   assign w_measured = {1'b0, r_cnt} + 17'd1;
   assign w_inWindow = inWindow(w_measured, MIN_V, MAX_V);
   assign w_accept   = (r_state == MEASURE) && w_edge && w_inWindow;
   assign w_reject   = (r_state == MEASURE) && w_edge && !w_inWindow;
   assign w_timeout  = (r_state == MEASURE) && !w_edge && (r_cnt == MAX_CNT);

   // State and output registers; all outputs come straight from flops.
   always_ff @(posedge clock_25mhz or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_run        <= '0;
         r_halfPeriod <= '0;
         r_valid      <= 1'b0;
         r_present    <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_cnt        <= w_cntNext;
         r_run        <= w_runNext;
         r_halfPeriod <= w_halfNext;
         r_valid      <= w_validNext;
         r_present    <= w_presentNext;
      end
   end

   // Next-state decisions: first edge arms the meter, later edges are judged
   // against the window, and a silent MAX_COUNT interval drops back to IDLE.
   always_comb begin
      w_stateNext   = r_state;
      w_cntNext     = r_cnt;
      w_runNext     = r_run;
      w_halfNext    = r_halfPeriod;
      w_validNext   = 1'b0;
      w_presentNext = r_present;
      case (r_state)
         IDLE: begin
            w_cntNext = '0;
            if (w_edge) begin
               w_stateNext = MEASURE;
            end
         end
         MEASURE: begin
            if (w_accept) begin
               w_cntNext     = '0;
               w_halfNext    = w_measured[15:0];
               w_validNext   = 1'b1;
               w_runNext     = (r_run >= LOCK_V) ? LOCK_V : (r_run + 4'd1);
               w_presentNext = (w_runNext == LOCK_V);
            end else if (w_reject) begin
               w_cntNext     = '0;
               w_runNext     = '0;
               w_presentNext = 1'b0;
            end else if (w_timeout) begin
               w_stateNext   = IDLE;
               w_cntNext     = '0;
               w_runNext     = '0;
               w_presentNext = 1'b0;
            end else begin
               w_cntNext = r_cnt + 16'd1;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
         end
      endcase
   end

   assign half_period  = r_halfPeriod;
   assign period_valid = r_valid;
   assign tone_present = r_present;

`ifdef SWEEP_DETECT_EN
   logic [15:0] r_prevPeriod;
   logic        r_prevValid;
   logic        r_sweepUp;
   logic        r_sweepDown;

   // Compare each accepted period with the previous one; a shorter period
   // means the pitch is rising. Any break in the run forgets the history.
   always_ff @(posedge clock_25mhz or posedge reset) begin
      if (reset) begin
         r_prevPeriod <= '0;
         r_prevValid  <= 1'b0;
         r_sweepUp    <= 1'b0;
         r_sweepDown  <= 1'b0;
      end else if (w_accept) begin
         if (r_prevValid) begin
            r_sweepUp   <= (w_measured[15:0] < r_prevPeriod);
            r_sweepDown <= (w_measured[15:0] > r_prevPeriod);
         end else begin
            r_sweepUp   <= 1'b0;
            r_sweepDown <= 1'b0;
         end
         r_prevPeriod <= w_measured[15:0];
         r_prevValid  <= 1'b1;
      end else if (w_reject || w_timeout) begin
         r_prevValid <= 1'b0;
         r_sweepUp   <= 1'b0;
         r_sweepDown <= 1'b0;
      end
   end

   assign sweep_up   = r_sweepUp;
   assign sweep_down = r_sweepDown;
`else
   assign sweep_up   = 1'b0;
   assign sweep_down = 1'b0;
`endif

endmodule

// File: tb/tb_tone_meter.sv
// tb_tone_meter: drives square waves with chosen or random edge spacing into
// tone_meter (scaled-down window) and checks every edge response and timeout
// against an interval-level reference model through a scoreboard queue.
`timescale 1ns/1ps
module tb_tone_meter;

   localparam int MIN_C  = 60;
   localparam int MAX_C  = 160;
   localparam int LOCK_C = 4;
`ifdef SWEEP_DETECT_EN
   localparam bit SWEEP_ON = 1'b1;
`else
   localparam bit SWEEP_ON = 1'b0;
`endif

   logic        clock_25mhz = 1'b0;
   logic        reset;
   logic        audio_in;
   logic [15:0] half_period;
   logic        period_valid;
   logic        tone_present;
   logic        sweep_up;
   logic        sweep_down;

   tone_meter #(
      .MIN_COUNT (MIN_C),
      .MAX_COUNT (MAX_C),
      .LOCK_N    (LOCK_C)
   ) dut (
      .clock_25mhz  (clock_25mhz),
      .reset        (reset),
      .audio_in     (audio_in),
      .half_period  (half_period),
      .period_valid (period_valid),
      .tone_present (tone_present),
      .sweep_up     (sweep_up),
      .sweep_down   (sweep_down)
   );

   // 25 MHz clock
   always #20 clock_25mhz = ~clock_25mhz;

   // Count rising clock edges so expectations can name an exact cycle
   int cyc = 0;
   always @(posedge clock_25mhz) cyc <= cyc + 1;

   typedef struct {
      int          cycle;
      bit          strobe;
      logic [15:0] half;
      bit          present;
      bit          up;
      bit          down;
      string       name;
   } rec_t;

   rec_t expQ[$];
   int   tests = 0;
   int   failures = 0;

   // Reference model state, kept per interval rather than per cycle
   bit          mMeasuring;
   int          mRun;
   logic [15:0] mHalf;
   bit          mPresent;
   int          mPrev;
   bit          mPrevValid;
   bit          mUp;
   bit          mDown;
   int          lastCyc;

   task automatic resetModel();
      mMeasuring = 0;
      mRun       = 0;
      mHalf      = '0;
      mPresent   = 0;
      mPrev      = 0;
      mPrevValid = 0;
      mUp        = 0;
      mDown      = 0;
   endtask

   task automatic pushRecord(input int cycleNo, input bit strobe, input string name);
      rec_t r;
      r.cycle   = cycleNo;
      r.strobe  = strobe;
      r.half    = mHalf;
      r.present = mPresent;
      r.up      = SWEEP_ON & mUp;
      r.down    = SWEEP_ON & mDown;
      r.name    = name;
      expQ.push_back(r);
   endtask

   task automatic checkOutput(input string name, input bit expValid, input logic [15:0] expHalf,
                              input bit expPresent, input bit expUp, input bit expDown);
      tests++;
      if (period_valid !== expValid || half_period !== expHalf || tone_present !== expPresent ||
          sweep_up !== expUp || sweep_down !== expDown) begin
         failures++;
         $display("[TB] FAIL %s @cycle %0d: got valid=%0b half=%0d present=%0b up=%0b down=%0b, expected valid=%0b half=%0d present=%0b up=%0b down=%0b",
                  name, cyc, period_valid, half_period, tone_present, sweep_up, sweep_down,
                  expValid, expHalf, expPresent, expUp, expDown);
      end
   endtask

   // Wait p cycles after the previous transition, toggle audio_in and record
   // what the meter must report; a gap longer than MAX+1 implies a timeout.
   task automatic applyStimulus(input int p);
      bit fromIdle;
      fromIdle = !mMeasuring;
      if (mMeasuring && p > MAX_C + 1) begin
         mRun = 0; mPresent = 0; mUp = 0; mDown = 0; mPrevValid = 0;
         pushRecord(lastCyc + 4 + MAX_C, 1'b0, "timeout");
         fromIdle = 1;
      end
      repeat (p) @(negedge clock_25mhz);
      audio_in = ~audio_in;
      lastCyc = cyc;
      if (fromIdle) begin
         mMeasuring = 1;
         pushRecord(lastCyc + 3, 1'b0, "first_edge");
      end else if (p >= MIN_C && p <= MAX_C) begin
         if (mPrevValid) begin
            mUp   = (p < mPrev);
            mDown = (p > mPrev);
         end else begin
            mUp = 0; mDown = 0;
         end
         mPrev = p; mPrevValid = 1;
         mHalf = 16'(p);
         mRun = (mRun < LOCK_C) ? mRun + 1 : LOCK_C;
         mPresent = (mRun == LOCK_C);
         pushRecord(lastCyc + 3, 1'b1, "accept");
      end else begin
         mRun = 0; mPresent = 0; mUp = 0; mDown = 0; mPrevValid = 0;
         pushRecord(lastCyc + 3, 1'b0, "reject");
      end
   endtask

   // Reset in the middle of an interval once pending responses are consumed
   task automatic applyReset();
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clock_25mhz);
      @(negedge clock_25mhz);
      reset = 1'b1;
      audio_in = 1'b0;
      #1;
      checkOutput("reset_async", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      expQ.delete();
      resetModel();
      repeat (3) @(negedge clock_25mhz);
      reset = 1'b0;
   endtask

   // Monitor: pop each expectation at its cycle and flag strobes nobody expected
   initial begin
      rec_t r;
      forever begin
         @(negedge clock_25mhz);
         if (!reset) begin
            while (expQ.size() > 0 && expQ[0].cycle < cyc) begin
               r = expQ.pop_front();
               tests++;
               failures++;
               $display("[TB] FAIL %s missed: expected at cycle %0d, now %0d", r.name, r.cycle, cyc);
            end
            if (expQ.size() > 0 && expQ[0].cycle == cyc) begin
               r = expQ.pop_front();
               checkOutput(r.name, r.strobe, r.half, r.present, r.up, r.down);
            end else if (period_valid) begin
               tests++;
               failures++;
               $display("[TB] FAIL spurious_strobe @cycle %0d: got valid=1 half=%0d, expected no strobe",
                        cyc, half_period);
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #4000000;
      $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "[TB] watchdog expired");
   end

   // Stimulus sequence
   initial begin
      int sel;
      resetModel();
      lastCyc  = 0;
      reset    = 1'b1;
      audio_in = 1'b0;
      repeat (3) @(negedge clock_25mhz);
      checkOutput("reset_state", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clock_25mhz);

      // steady tone, lock on the 4th strobe
      applyStimulus(10);
      for (int i = 0; i < 5; i++) applyStimulus(100);

      // window boundaries, edge-with-timeout, and true timeout
      applyStimulus(MIN_C);
      applyStimulus(MAX_C);
      applyStimulus(MIN_C - 1);
      applyStimulus(MIN_C);
      applyStimulus(MAX_C + 1);
      applyStimulus(MAX_C + 2);
      applyStimulus(100);

      // glitch while locked, then relock
      for (int i = 0; i < 4; i++) applyStimulus(110);
      applyStimulus(20);
      applyStimulus(90);
      for (int i = 0; i < 4; i++) applyStimulus(110);

      // pitch sweep
      applyStimulus(120);
      applyStimulus(119);
      applyStimulus(118);
      applyStimulus(119);

      // reset mid-interval while locked, then restart
      for (int i = 0; i < 4; i++) applyStimulus(100);
      repeat (5) @(negedge clock_25mhz);
      applyReset();
      applyStimulus(50);
      applyStimulus(100);
      applyStimulus(100);

      // randomized spacing: mostly near the window, plus glitches and silences
      for (int i = 0; i < 150; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 70)      applyStimulus(int'($urandom_range(MIN_C - 3, MAX_C + 2)));
         else if (sel < 85) applyStimulus(int'($urandom_range(1, MIN_C - 1)));
         else               applyStimulus(int'($urandom_range(MAX_C + 2, MAX_C + 40)));
      end

      // lock, then long silence
      for (int i = 0; i < 5; i++) applyStimulus(100);
      applyStimulus(MAX_C + 50);

      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clock_25mhz);
      if (expQ.size() > 0) begin
         tests++;
         failures++;
         $display("[TB] FAIL drain: %0d expectations still pending, required 0", expQ.size());
      end
      repeat (10) @(negedge clock_25mhz);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
